// File: rtl/fifo_rd_adapter_if.sv
// Read-side handshake bundle: FIFO read port plus the downstream valid/ready stream.
// The master modport is the adapter; the slave modport is the FIFO/consumer environment.
interface fifo_rd_adapter_if #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
);
    logic                 rempty;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rinc;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [CNT_W-1:0]     rd_count;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_data, m_valid, rd_count
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_data, m_valid, rd_count
    );
endinterface

// File: rtl/fifo_rd_adapter.sv
// FIFO read-port drain into a registered 2-entry valid/ready stream (read clock domain).
// Optional delivered-word counter enabled by defining FIFO_RD_ADAPT_CNT_EN.
//
// state | meaning
// EMPTY | no word buffered, m_valid low
// ONE   | head holds the word on m_data
// TWO   | head + skid full, FIFO pops stall
module fifo_rd_adapter #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_adapter_if.master bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_SIZE-1:0] head, head_nxt;
    logic [DATA_SIZE-1:0] skid, skid_nxt;
    logic                 valid_q;
    logic                 push;
    logic                 pop;

    // Pop strobe sees only registered occupancy and rempty, never m_ready.
    assign push = !rrst && !bus.rempty && (state != TWO);
    assign pop  = valid_q && bus.m_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = bus.rdata;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = TWO;
                    skid_nxt  = bus.rdata;
                end else if (push && pop) begin
                    head_nxt  = bus.rdata;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = skid;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Dedicated valid flop so m_valid stays glitch-free across ONE<->TWO encoding changes.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            head    <= head_nxt;
            skid    <= skid_nxt;
            valid_q <= (state_nxt != EMPTY);
        end
    end

    assign bus.rinc    = push;
    assign bus.m_valid = valid_q;
    assign bus.m_data  = head;

`ifdef FIFO_RD_ADAPT_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.rd_count = cnt;
`else
    assign bus.rd_count = '0;
`endif
endmodule
